// File: rtl/blink_multi.sv
// Multi-channel LED pattern generator: shared prescaler and 16-step phase drive per-channel off/on/blink/heartbeat.
// Optional feature macro BLINK_PWM_EN adds duty_i and a free-running 4-bit PWM brightness gate.
module blink_multi #(
   parameter int unsigned FREQ     = 0,
   parameter int unsigned SECS     = 0,
   parameter int unsigned CHANNELS = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    sync_i,
   input  logic [2*CHANNELS-1:0]   mode_i,
`ifdef BLINK_PWM_EN
   input  logic [4*CHANNELS-1:0]   duty_i,
`endif
   output logic [CHANNELS-1:0]     led_o,
   output logic                    wrap_o
);

   localparam int unsigned TICK_CYC = (FREQ * SECS) / 16;
   localparam int unsigned PW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

   if (FREQ == 0) begin : g_bad_freq
      $fatal(1, "blink_multi: FREQ must be nonzero");
   end
   if (SECS == 0) begin : g_bad_secs
      $fatal(1, "blink_multi: SECS must be nonzero");
   end
   if (TICK_CYC < 1) begin : g_bad_tick
      $fatal(1, "blink_multi: FREQ*SECS/16 must be at least 1");
   end
   if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
      $fatal(1, "blink_multi: CHANNELS must be in 1..32");
   end

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ON    = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_HEART = 2'b11
   } mode_t;

   logic [PW-1:0]           presc;
   logic [3:0]              phase;
   logic [2*CHANNELS-1:0]   shadow_mode;
   logic [CHANNELS-1:0]     pattern;
   logic                    tick;
   logic                    wrap;
   logic                    load;

   assign tick = (presc == PW'(TICK_CYC - 1));
   assign wrap = tick && (phase == 4'd15);
   // Modes (and duty) only change at a pattern boundary or on an explicit restart.
   assign load = sync_i || wrap;

`ifdef BLINK_PWM_EN
   logic [3:0]              pwm_cnt;
   logic [4*CHANNELS-1:0]   shadow_duty;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pwm_cnt     <= 4'd0;
         shadow_duty <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 4'd1;
         if (load) begin
            shadow_duty <= duty_i;
         end
      end
   end
`endif

   always_comb begin
      pattern = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         case (mode_t'(shadow_mode[2*i +: 2]))
            MODE_OFF:   pattern[i] = 1'b0;
            MODE_ON:    pattern[i] = 1'b1;
            MODE_BLINK: pattern[i] = ~phase[3];
            MODE_HEART: pattern[i] = (phase == 4'd0) || (phase == 4'd1) ||
                                     (phase == 4'd3) || (phase == 4'd4);
            default:    pattern[i] = 1'b0;
         endcase
`ifdef BLINK_PWM_EN
         if (pwm_cnt >= shadow_duty[4*i +: 4]) begin
            pattern[i] = 1'b0;
         end
`endif
      end
   end

   // sync_i wins over tick and wrap, and suppresses the wrap pulse.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         presc       <= '0;
         phase       <= 4'd0;
         shadow_mode <= '0;
         led_o       <= '0;
         wrap_o      <= 1'b0;
      end else begin
         led_o  <= pattern;
         wrap_o <= wrap && !sync_i;
         if (sync_i) begin
            presc <= '0;
            phase <= 4'd0;
         end else if (tick) begin
            presc <= '0;
            phase <= phase + 4'd1;
         end else begin
            presc <= presc + PW'(1);
         end
         if (load) begin
            shadow_mode <= mode_i;
         end
      end
   end

endmodule

// File: tb/tb_blink_multi.sv
// Scoreboard bench for blink_multi: a cycle-count reference model pushes expected outputs, a monitor pops and compares.
// Works with or without BLINK_PWM_EN defined.
module tb_blink_multi;

   localparam int FREQ   = 32;
   localparam int SECS   = 1;
   localparam int CH     = 4;
   localparam int TICK   = (FREQ * SECS) / 16;
   localparam int PERIOD = 16 * TICK;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              sync_i;
   logic [2*CH-1:0]   mode_i;
   logic [4*CH-1:0]   duty_v;
   logic [CH-1:0]     led_o;
   logic              wrap_o;

   blink_multi #(.FREQ(FREQ), .SECS(SECS), .CHANNELS(CH)) dut (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .sync_i (sync_i),
      .mode_i (mode_i),
`ifdef BLINK_PWM_EN
      .duty_i (duty_v),
`endif
      .led_o  (led_o),
      .wrap_o (wrap_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [CH-1:0] led;
      logic          wrap;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference state: edges since last restart, shadow modes/duties, edges since reset for PWM.
   int          m_cnt;
   logic [1:0]  m_mode [CH];
   int          m_duty [CH];
   int          m_pwm;

   function automatic logic patt_bit(input logic [1:0] m, input int ph);
      case (m)
         2'b00:   return 1'b0;
         2'b01:   return 1'b1;
         2'b10:   return ph < 8;
         default: return ph inside {0, 1, 3, 4};
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0;
      m_pwm = 0;
      for (int c = 0; c < CH; c++) begin
         m_mode[c] = 2'b00;
         m_duty[c] = 0;
      end
   endtask

   task automatic model_load(input logic [2*CH-1:0] m, input logic [4*CH-1:0] d);
      for (int c = 0; c < CH; c++) begin
         m_mode[c] = m[2*c +: 2];
         m_duty[c] = int'(d[4*c +: 4]);
      end
   endtask

   // Drive one cycle of inputs and push what the outputs must be after the next rising edge.
   task automatic applyStimulus(input logic s, input logic [2*CH-1:0] m, input logic [4*CH-1:0] d);
      exp_t e;
      int   ph;
      @(negedge clk_i);
      sync_i = s;
      mode_i = m;
      duty_v = d;
      ph = (m_cnt / TICK) % 16;
      for (int c = 0; c < CH; c++) begin
         e.led[c] = patt_bit(m_mode[c], ph);
`ifdef BLINK_PWM_EN
         if (m_pwm >= m_duty[c]) e.led[c] = 1'b0;
`endif
      end
      if (s) begin
         e.wrap = 1'b0;
         m_cnt  = 0;
         model_load(m, d);
      end else begin
         m_cnt  = (m_cnt + 1) % PERIOD;
         e.wrap = (m_cnt == 0);
         if (e.wrap) model_load(m, d);
      end
      m_pwm = (m_pwm + 1) % 16;
      exp_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk_i);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("led", 32'(led_o), 32'(e.led));
            checkOutput("wrap", 32'(wrap_o), 32'(e.wrap));
         end
      end
   end

   initial begin : stimulus
      logic [2*CH-1:0] base_mode;
      logic [4*CH-1:0] base_duty;
      rst_i  = 1'b1;
      sync_i = 1'b0;
      mode_i = '0;
      duty_v = '0;
      model_reset();
      repeat (3) @(negedge clk_i);
      checkOutput("reset_led", 32'(led_o), 32'd0);
      checkOutput("reset_wrap", 32'(wrap_o), 32'd0);
      @(posedge clk_i);
      #2;
      rst_i = 1'b0;

      // Modes off until first boundary, then ch0 on, ch1 blink, ch2 heartbeat, ch3 off.
      base_mode = 8'b00_11_10_01;
      base_duty = 16'hFFF4;
      repeat (10) applyStimulus(1'b0, base_mode, base_duty);
      applyStimulus(1'b1, base_mode, base_duty);
      repeat (80) applyStimulus(1'b0, base_mode, base_duty);

      // ch0 to off mid-period: old shadow holds until the wrap.
      repeat (40) applyStimulus(1'b0, 8'b00_11_10_00, base_duty);

      // sync exactly on a wrap edge.
      for (int i = 0; i < PERIOD && (m_cnt % PERIOD) != PERIOD - 1; i++)
         applyStimulus(1'b0, base_mode, base_duty);
      applyStimulus(1'b1, base_mode, base_duty);
      repeat (40) applyStimulus(1'b0, base_mode, base_duty);

      // sync held high: restart state with phase-0 pattern.
      repeat (5) applyStimulus(1'b1, 8'b11_11_10_01, 16'h0F37);
      repeat (10) applyStimulus(1'b0, 8'b11_11_10_01, 16'h0F37);

      // All on, then async reset at phase 9.
      applyStimulus(1'b1, 8'b01_01_01_01, 16'hFFFF);
      for (int i = 0; i < PERIOD && ((m_cnt / TICK) % 16) != 9; i++)
         applyStimulus(1'b0, 8'b01_01_01_01, 16'hFFFF);
      @(negedge clk_i);
      #1;
      rst_i = 1'b1;
      #1;
      checkOutput("midreset_led", 32'(led_o), 32'd0);
      checkOutput("midreset_wrap", 32'(wrap_o), 32'd0);
      model_reset();
      repeat (2) @(negedge clk_i);
      @(posedge clk_i);
      #2;
      rst_i = 1'b0;
      repeat (70) applyStimulus(1'b0, 8'b01_01_01_01, 16'hFFFF);

      // Randomized modes, duties and occasional sync.
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 39) == 0), 8'($urandom), 16'($urandom));
      end

      @(posedge clk_i);
      #3;
      checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
